// File: rtl/imm_gen_lanes_pkg.sv
// ============================================================================
// imm_gen_lanes_pkg: shared immediate-select encodings and widths.  rev 1.0
// ============================================================================
`default_nettype none

`ifndef IMM_TYPE_SEL
`define IMM_TYPE_SEL     3
`define IMM_TYPE_NONE    0
`define IMM_TYPE_I       1
`define IMM_TYPE_S       2
`define IMM_TYPE_B       3
`define IMM_TYPE_U       4
`define IMM_TYPE_J       5
`define IMM_TYPE_Z       6
`define RV32_INST_WIDTH  32
`define RV32_DATA_WIDTH  32
`endif

package imm_gen_lanes_pkg;
  localparam int IMM_TYPE_SEL    = `IMM_TYPE_SEL;
  localparam int RV32_INST_WIDTH = `RV32_INST_WIDTH;
  localparam int RV32_DATA_WIDTH = `RV32_DATA_WIDTH;

  // Encoding 7 is reserved and reported as illegal by the lane decoder.
  typedef enum logic [IMM_TYPE_SEL-1:0] {
    IMM_NONE = IMM_TYPE_SEL'(`IMM_TYPE_NONE),
    IMM_I    = IMM_TYPE_SEL'(`IMM_TYPE_I),
    IMM_S    = IMM_TYPE_SEL'(`IMM_TYPE_S),
    IMM_B    = IMM_TYPE_SEL'(`IMM_TYPE_B),
    IMM_U    = IMM_TYPE_SEL'(`IMM_TYPE_U),
    IMM_J    = IMM_TYPE_SEL'(`IMM_TYPE_J),
    IMM_Z    = IMM_TYPE_SEL'(`IMM_TYPE_Z)
  } imm_type_e;
endpackage

`default_nettype wire

// File: rtl/imm_decode_lane.sv
// ============================================================================
// imm_decode_lane: combinational immediate extraction for one lane.  rev 1.0
// ============================================================================
`default_nettype none

module imm_decode_lane
  import imm_gen_lanes_pkg::*;
#(
  parameter int XLEN = RV32_DATA_WIDTH
) (
  input  logic [RV32_INST_WIDTH-1:0] inst,
  input  logic [IMM_TYPE_SEL-1:0]    sel,
  output logic [XLEN-1:0]            imm,
  output logic                       illegal
);

  // Opcode bits carry no immediate information.
  logic w_unused_opcode;
  assign w_unused_opcode = ^inst[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (sel)
      IMM_NONE: imm = '0;
      IMM_I:    imm = XLEN'($signed(inst[31:20]));
      IMM_S:    imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:    imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:    imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:    imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      IMM_Z:    imm = XLEN'(inst[19:15]);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_lanes.sv
// ============================================================================
// imm_gen_lanes: LANES-wide registered immediate generator, 2-entry skid buffer.
// rev 1.0
// ============================================================================
`default_nettype none

module imm_gen_lanes
  import imm_gen_lanes_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = RV32_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [LANES-1:0]              i_lane_valid,
  input  logic [32*LANES-1:0]           i_inst,
  input  logic [IMM_TYPE_SEL*LANES-1:0] i_imm_type_sel,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [LANES-1:0]              o_lane_valid,
  output logic [XLEN*LANES-1:0]         o_imm,
  output logic [LANES-1:0]              o_illegal
);

  logic [XLEN*LANES-1:0] w_imm;
  logic [LANES-1:0]      w_illegal;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [XLEN-1:0] w_lane_imm;
    logic            w_lane_illegal;

    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .inst    (i_inst[32*k +: 32]),
      .sel     (i_imm_type_sel[IMM_TYPE_SEL*k +: IMM_TYPE_SEL]),
      .imm     (w_lane_imm),
      .illegal (w_lane_illegal)
    );

    // Empty lanes must present clean zeros downstream.
    assign w_imm[XLEN*k +: XLEN] = i_lane_valid[k] ? w_lane_imm : '0;
    assign w_illegal[k]          = i_lane_valid[k] & w_lane_illegal;
  end

  logic                   r_m_valid, r_k_valid;
  logic [LANES-1:0]       r_m_mask, r_k_mask;
  logic [XLEN*LANES-1:0]  r_m_imm, r_k_imm;
  logic [LANES-1:0]       r_m_ill, r_k_ill;

  logic w_accept, w_m_free;
  assign w_accept = i_in_valid && !r_k_valid && !i_flush;
  assign w_m_free = !r_m_valid || i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_mask  <= '0;
      r_m_imm   <= '0;
      r_m_ill   <= '0;
      r_k_valid <= 1'b0;
      r_k_mask  <= '0;
      r_k_imm   <= '0;
      r_k_ill   <= '0;
    end else if (i_flush) begin
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (w_m_free) begin
      // Skid entry is older than anything arriving now; accept implies K empty.
      if (r_k_valid) begin
        r_m_valid <= 1'b1;
        r_m_mask  <= r_k_mask;
        r_m_imm   <= r_k_imm;
        r_m_ill   <= r_k_ill;
        r_k_valid <= 1'b0;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_mask  <= i_lane_valid;
        r_m_imm   <= w_imm;
        r_m_ill   <= w_illegal;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_k_valid <= 1'b1;
      r_k_mask  <= i_lane_valid;
      r_k_imm   <= w_imm;
      r_k_ill   <= w_illegal;
    end
  end

  assign o_in_ready   = !r_k_valid;
  assign o_out_valid  = r_m_valid;
  assign o_lane_valid = r_m_mask;
  assign o_imm        = r_m_imm;
  assign o_illegal    = r_m_ill;

endmodule

`default_nettype wire
